// File: rtl/dmem_responder_if.sv
// Data-memory port between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  data_ce_i;
    logic                  data_we_i;
    logic                  data_re_i;
    logic [2:0]            data_size_i;
    logic [DATA_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [DATA_WIDTH-1:0] data_rdata_o;
    logic                  data_ready_o;
    logic                  data_err_o;
    logic                  busy_o;

    modport master (
        output data_ce_i, data_we_i, data_re_i, data_size_i, data_addr_i, data_wdata_i,
        input  data_rdata_o, data_ready_o, data_err_o, busy_o
    );

    modport slave (
        input  data_ce_i, data_we_i, data_re_i, data_size_i, data_addr_i, data_wdata_i,
        output data_rdata_o, data_ready_o, data_err_o, busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait, byte-lane stores
// and sign/zero-extended loads into a private array of 32-bit words.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  req;
    logic                  latch;
    logic                  exec;

    logic [DATA_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic                  we_p0;
    logic [2:0]            size_p0;

    logic [DATA_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_we;
    logic [2:0]            acc_size;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [31:0]           rword;
    logic                  unused_addr_hi;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [31:0]           mem [WORDS];

    function automatic logic access_error(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000, 3'b100: access_error = 1'b0;
            3'b001, 3'b101: access_error = a[0];
            3'b010:         access_error = (a != 2'b00);
            default:        access_error = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {a, 3'b000});
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'b0, b};
            3'b101:  load_extend = {16'b0, h};
            default: load_extend = 32'b0;
        endcase
    endfunction

    assign req = bus.data_ce_i & (bus.data_we_i | bus.data_re_i);

    // With WAIT_CYCLES=0 the access executes straight out of IDLE on the live inputs.
    assign acc_addr  = (state_q == ST_IDLE) ? bus.data_addr_i  : addr_p0;
    assign acc_wdata = (state_q == ST_IDLE) ? bus.data_wdata_i : wdata_p0;
    assign acc_we    = (state_q == ST_IDLE) ? bus.data_we_i    : we_p0;
    assign acc_size  = (state_q == ST_IDLE) ? bus.data_size_i  : size_p0;

    assign acc_idx        = acc_addr[DEPTH_LOG2+1:2];
    assign lane           = acc_addr[1:0];
    assign acc_err        = access_error(acc_size, lane);
    assign rword          = mem[acc_idx];
    assign unused_addr_hi = ^acc_addr[DATA_WIDTH-1:DEPTH_LOG2+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    cnt_d = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        exec    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    exec    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wlanes = acc_wdata[31:0];
        be     = 4'b1111;
        case (acc_size[1:0])
            2'b00: begin
                wlanes = {4{acc_wdata[7:0]}};
                be     = 4'b0001 << lane;
            end
            2'b01: begin
                wlanes = {2{acc_wdata[15:0]}};
                be     = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (exec) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= '0;
                end else if (!acc_we) begin
                    rdata_q <= DATA_WIDTH'(load_extend(rword, acc_size, lane));
                end
            end
        end
    end

    // Request capture stage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_p0  <= bus.data_addr_i;
            wdata_p0 <= bus.data_wdata_i;
            we_p0    <= bus.data_we_i;
            size_p0  <= bus.data_size_i;
        end
    end

    // A reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (exec && !rst && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[acc_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign bus.data_rdata_o = rdata_q;
    assign bus.data_ready_o = (state_q == ST_DONE);
    assign bus.data_err_o   = (state_q == ST_DONE) & err_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
endmodule
